mem_port_arbiter: RTL and testbench

Shares the single-port unified instruction/data RAM (`Mem_I_D`, 13-bit word address, big-endian 16-bit halves, registered read) between three requesters: CPU instruction fetch, CPU load/store, and the IO polling engine. Arbitrates on fixed priority, sequences each access through a 4-state FSM that hides the RAM's one-cycle read latency, and returns data with a one-cycle ack pulse. Sits between the CPU/IO blocks and the RAM instance at top level.

---
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: fixed-priority D > I > IO sharing of the unified RAM port; ARB_IO_STARVE_GUARD_EN adds an IO anti-starvation counter
module mem_port_arbiter #(
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_half,
  input  logic              d_bsel,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  input  logic              io_req,
  input  logic              io_we,
  input  logic [ADDR_W-1:0] io_addr,
  input  logic [31:0]       io_wdata,
  output logic              io_ack,
  output logic [31:0]       io_rdata,
  output logic              mem_we,
  output logic              mem_half,
  output logic              mem_bsel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_din,
  input  logic [31:0]       mem_dout
);
  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, ACK} state_t;
  typedef enum logic [1:0] {G_NONE, G_D, G_I, G_IO} gnt_t;
  state_t            state, state_nxt;
  gnt_t              gnt, gnt_nxt, win;
  logic              grant, io_force, w_we, w_half, w_bsel;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_din;
`ifdef ARB_IO_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve;
  logic          starve_full;
  assign starve_full = 32'(starve) >= 32'(STARVE_LIMIT);
  assign io_force    = io_req && starve_full;
  // count IO arbitration losses, saturating; cleared when IO wins or stops asking
  always_ff @(posedge clk)
    if (rst) starve <= '0;
    else if (state == IDLE)
      starve <= (!io_req || win == G_IO) ? '0 : starve_full ? starve : starve + CW'(1);
`else
  assign io_force = 1'b0;
`endif
  // state and grant registers
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      gnt   <= G_NONE;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
    end
  // winner selection and next-state sequencing
  always_comb begin
    win       = io_force ? G_IO : d_req ? G_D : i_req ? G_I : io_req ? G_IO : G_NONE;
    grant     = state == IDLE && win != G_NONE;
    w_addr    = win == G_D ? d_addr : win == G_I ? i_addr : io_addr;
    w_we      = win == G_D ? d_we : win == G_IO && io_we;
    w_half    = win == G_D && d_half;
    w_bsel    = win == G_D && d_bsel;
    w_din     = win == G_D ? d_wdata : win == G_IO ? io_wdata : '0;
    gnt_nxt   = state == IDLE ? win : state == ACK ? G_NONE : gnt;
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = grant ? ISSUE : IDLE;
      ISSUE:   state_nxt = mem_we ? ACK : CAPTURE;
      CAPTURE: state_nxt = ACK;
      ACK:     state_nxt = IDLE;
    endcase
  end
  // RAM port registers: loaded on grant, write enable lives only through ISSUE
  always_ff @(posedge clk)
    if (rst) begin
      mem_we   <= 1'b0;
      mem_half <= 1'b0;
      mem_bsel <= 1'b0;
      mem_addr <= '0;
      mem_din  <= '0;
    end else begin
      mem_we <= grant && w_we;
      if (grant) begin
        mem_half <= w_half;
        mem_bsel <= w_bsel;
        mem_addr <= w_addr;
        mem_din  <= w_din;
      end
    end
  // capture registered RAM data into the winner's read-data holding register
  always_ff @(posedge clk)
    if (rst) begin
      d_rdata  <= '0;
      i_rdata  <= '0;
      io_rdata <= '0;
    end else if (state == CAPTURE) begin
      if (gnt == G_D) d_rdata <= mem_dout;
      if (gnt == G_I) i_rdata <= mem_dout;
      if (gnt == G_IO) io_rdata <= mem_dout;
    end
  // one-cycle ack to the granted requester
  always_comb begin
    d_ack  = state == ACK && gnt == G_D;
    i_ack  = state == ACK && gnt == G_I;
    io_ack = state == ACK && gnt == G_IO;
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and randomized rounds against a transaction-level model
module tb_mem_port_arbiter;
  localparam int AW = 13;
  logic clk = 1'b0, rst = 1'b1;
  logic i_req = 1'b0, i_ack;
  logic [AW-1:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic d_req = 1'b0, d_we = 1'b0, d_half = 1'b0, d_bsel = 1'b0, d_ack;
  logic [AW-1:0] d_addr = '0;
  logic [31:0] d_wdata = '0, d_rdata;
  logic io_req = 1'b0, io_we = 1'b0, io_ack;
  logic [AW-1:0] io_addr = '0;
  logic [31:0] io_wdata = '0, io_rdata;
  logic mem_we, mem_half, mem_bsel;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_din, mem_dout;

  mem_port_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_half(d_half), .d_bsel(d_bsel),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
    .io_req(io_req), .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata),
    .io_ack(io_ack), .io_rdata(io_rdata),
    .mem_we(mem_we), .mem_half(mem_half), .mem_bsel(mem_bsel),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  logic [31:0] ram [0:8191];
  always @(posedge clk) begin
    if (mem_we) begin
      if (!mem_half) ram[mem_addr] <= mem_din;
      else if (mem_bsel) ram[mem_addr][15:0] <= mem_din[15:0];
      else ram[mem_addr][31:16] <= mem_din[15:0];
    end
    mem_dout <= mem_half ? {16'h0, mem_bsel ? ram[mem_addr][15:0] : ram[mem_addr][31:16]} : ram[mem_addr];
  end

  int total = 0, bad = 0;
  logic rq_we[3], rq_half[3], rq_bsel[3];
  logic [AW-1:0] rq_addr[3];
  logic [31:0] rq_wdata[3];
  int obs_t[3];
  logic [31:0] obs_rd[3];
  int we_cnt;
  logic seen_half, seen_bsel;
  logic [31:0] ref_mem [int];

  typedef struct {
    int r; logic we, half, bsel; logic [AW-1:0] addr; logic [31:0] wdata; int lat; logic [31:0] rd;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", n, a, e, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(logic [AW-1:0] a, logic h, logic b);
    logic [31:0] v = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    return h ? {16'h0, b ? v[15:0] : v[31:16]} : v;
  endfunction

  function automatic void ref_wr(logic [AW-1:0] a, logic h, logic b, logic [31:0] d);
    logic [31:0] v = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
    if (!h) v = d;
    else if (b) v[15:0] = d[15:0];
    else v[31:16] = d[15:0];
    ref_mem[int'(a)] = v;
  endfunction

  function automatic logic [31:0] rdata_of(int r);
    return r == 0 ? d_rdata : r == 1 ? i_rdata : io_rdata;
  endfunction

  task automatic drive(int r, logic on);
    if (r == 0) begin
      d_req = on; d_we = rq_we[0]; d_half = rq_half[0]; d_bsel = rq_bsel[0];
      d_addr = rq_addr[0]; d_wdata = rq_wdata[0];
    end else if (r == 1) begin
      i_req = on; i_addr = rq_addr[1];
    end else begin
      io_req = on; io_we = rq_we[2]; io_addr = rq_addr[2]; io_wdata = rq_wdata[2];
    end
  endtask

  // called at a negedge; each request is held until its own ack, then dropped
  task automatic round(input logic [2:0] act);
    logic [2:0] pend, acks;
    int t;
    pend = act; t = 0; we_cnt = 0; seen_half = 1'b0; seen_bsel = 1'b0;
    for (int r = 0; r < 3; r++) begin
      obs_t[r] = -1;
      if (act[r]) drive(r, 1'b1);
    end
    while (pend != 3'b000 && t < 60) begin
      @(negedge clk);
      t++;
      if (mem_we) begin we_cnt++; seen_half = mem_half; seen_bsel = mem_bsel; end
      acks = {io_ack, i_ack, d_ack};
      chk("stray_ack", 32'(acks & ~pend), 32'h0);
      for (int r = 0; r < 3; r++)
        if (acks[r] && pend[r]) begin
          obs_t[r] = t; obs_rd[r] = rdata_of(r); pend[r] = 1'b0; drive(r, 1'b0);
        end
    end
    chk("all_acked", 32'(pend), 32'h0);
  endtask

  initial begin
    int start, lat, io_first, io_seen;
    logic [2:0] act;
    for (int k = 0; k < 8192; k++) ram[k] = '0;
    tbl[0]  = '{2, 1'b1, 1'b0, 1'b0, 13'h0010, 32'h12345678, 2, 32'h0};
    tbl[1]  = '{1, 1'b0, 1'b0, 1'b0, 13'h0010, 32'h0, 3, 32'h12345678};
    tbl[2]  = '{0, 1'b1, 1'b0, 1'b0, 13'h0020, 32'hCAFE0123, 2, 32'h0};
    tbl[3]  = '{0, 1'b1, 1'b1, 1'b1, 13'h0020, 32'h0000BEEF, 2, 32'h0};
    tbl[4]  = '{0, 1'b0, 1'b0, 1'b0, 13'h0020, 32'h0, 3, 32'hCAFEBEEF};
    tbl[5]  = '{0, 1'b1, 1'b1, 1'b0, 13'h0020, 32'h00001234, 2, 32'h0};
    tbl[6]  = '{2, 1'b0, 1'b0, 1'b0, 13'h0020, 32'h0, 3, 32'h1234BEEF};
    tbl[7]  = '{0, 1'b0, 1'b1, 1'b0, 13'h0020, 32'h0, 3, 32'h00001234};
    tbl[8]  = '{2, 1'b1, 1'b0, 1'b0, 13'h1FFF, 32'hA5A5A5A5, 2, 32'h0};
    tbl[9]  = '{1, 1'b0, 1'b0, 1'b0, 13'h1FFF, 32'h0, 3, 32'hA5A5A5A5};
    tbl[10] = '{0, 1'b0, 1'b0, 1'b0, 13'h0010, 32'h0, 3, 32'h12345678};
    for (int r = 0; r < 3; r++) begin
      rq_we[r] = 1'b0; rq_half[r] = 1'b0; rq_bsel[r] = 1'b0;
      rq_addr[r] = 13'(32'h40 + r); rq_wdata[r] = '0;
    end
    // reset held with every requester asking
    for (int r = 0; r < 3; r++) drive(r, 1'b1);
    repeat (3) @(negedge clk);
    chk("rst_acks", 32'({d_ack, i_ack, io_ack}), 32'h0);
    chk("rst_rdata", d_rdata | i_rdata | io_rdata, 32'h0);
    chk("rst_mem_ctl", 32'({mem_we, mem_half, mem_bsel, mem_addr}), 32'h0);
    chk("rst_mem_din", mem_din, 32'h0);
    // release: D first, then I, then IO, all reads
    rst = 1'b0;
    round(3'b111);
    chk("all3_d_t", obs_t[0], 3);
    chk("all3_i_t", obs_t[1], 7);
    chk("all3_io_t", obs_t[2], 11);
    // directed single-requester table
    for (int k = 0; k < 11; k++) begin
      int r;
      @(negedge clk);
      r = tbl[k].r;
      rq_we[r] = tbl[k].we; rq_half[r] = tbl[k].half; rq_bsel[r] = tbl[k].bsel;
      rq_addr[r] = tbl[k].addr; rq_wdata[r] = tbl[k].wdata;
      round(3'(1 << r));
      chk($sformatf("vec%0d_lat", k), obs_t[r], tbl[k].lat);
      chk($sformatf("vec%0d_wecnt", k), we_cnt, 32'(tbl[k].we));
      if (tbl[k].we) begin
        chk($sformatf("vec%0d_halfsel", k), 32'({seen_half, seen_bsel}), 32'({tbl[k].half, tbl[k].bsel}));
        ref_wr(tbl[k].addr, tbl[k].half, tbl[k].bsel, tbl[k].wdata);
      end else chk($sformatf("vec%0d_rdata", k), obs_rd[r], tbl[k].rd);
    end
    chk("io_rdata_hold", io_rdata, 32'h1234BEEF);
    chk("i_rdata_hold", i_rdata, 32'hA5A5A5A5);
    // reset during CAPTURE of a D read
    @(negedge clk);
    rq_we[0] = 1'b0; rq_half[0] = 1'b0; rq_bsel[0] = 1'b0; rq_addr[0] = 13'h0020;
    drive(0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rstcap_ack", 32'(d_ack), 32'h0);
    chk("rstcap_rdata", d_rdata, 32'h0);
    chk("rstcap_we", 32'(mem_we), 32'h0);
    rst = 1'b0;
    drive(0, 1'b0);
    @(negedge clk);
    chk("rstcap_idle_ack", 32'({d_ack, i_ack, io_ack}), 32'h0);
    round(3'b001);
    chk("rstcap_relat", obs_t[0], 3);
    chk("rstcap_rerd", obs_rd[0], 32'h1234BEEF);
    // randomized rounds against the transaction-level model
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      act = 3'($urandom_range(1, 7));
      for (int r = 0; r < 3; r++) begin
        rq_we[r] = r != 1 && $urandom_range(0, 1) == 1;
        rq_half[r] = r == 0 && $urandom_range(0, 1) == 1;
        rq_bsel[r] = r == 0 && $urandom_range(0, 1) == 1;
        rq_addr[r] = 13'($urandom_range(0, 15));
        rq_wdata[r] = $urandom;
      end
      round(act);
      start = 0;
      for (int r = 0; r < 3; r++)
        if (act[r]) begin
          lat = rq_we[r] ? 2 : 3;
          chk($sformatf("rnd%0d_r%0d_t", n, r), obs_t[r], start + lat);
          if (rq_we[r]) ref_wr(rq_addr[r], rq_half[r], rq_bsel[r], rq_wdata[r]);
          else chk($sformatf("rnd%0d_r%0d_rd", n, r), obs_rd[r], ref_rd(rq_addr[r], rq_half[r], rq_bsel[r]));
          start += lat + 1;
        end
    end
    // IO starvation under continuous D and I traffic
    @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      rq_we[r] = 1'b0; rq_half[r] = 1'b0; rq_bsel[r] = 1'b0;
      drive(r, 1'b1);
    end
    io_first = -1; io_seen = 0;
    for (int t = 1; t <= 100; t++) begin
      @(negedge clk);
      if (io_ack) begin
        io_seen++;
        if (io_first < 0) io_first = t;
        io_req = 1'b0;
      end
    end
`ifdef ARB_IO_STARVE_GUARD_EN
    chk("io_forced_t", io_first, 11);
`else
    chk("io_starved", io_seen, 0);
`endif
    for (int r = 0; r < 3; r++) drive(r, 1'b0);
    repeat (8) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
